// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and defaults for the external SRAM controller.
// Rev 1.0
`default_nettype none

package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 5;
    localparam logic [31:0] DEFAULT_ADDR_BASE   = 32'd1024;
    localparam int unsigned SRAM_DW             = 16;

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: clearable per-phase wait counter, last_o flags count WAIT_CYCLES-1.
// Rev 1.0
`default_nettype none

module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign last_o = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage loads/stores into two timed 16-bit SRAM accesses.
// Rev 1.0 -- optional SRAM_STALL_CNT_EN adds a saturating stall_count output.
`default_nettype none

module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
`ifdef SRAM_STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    state_e             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0] w_offset;
    logic        w_active;
    logic        w_cnt_last;
    logic        w_last;
    logic        w_unused;

    assign w_offset = address - ADDR_BASE;
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign w_active = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign w_last   = w_active && w_cnt_last;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (~w_active),
        .en_i  (w_active),
        .last_o(w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request inputs are only looked at in IDLE; a started transaction always runs to DONE.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ST_LOW;
                    op_wr_d = wr_en;
                    word_d  = w_offset[SRAM_AW:2];
                    wdata_d = write_data;
                end
            end
            ST_LOW:  if (w_last) state_d = ST_HIGH;
            ST_HIGH: if (w_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_last && !op_wr_q) begin
            if (state_q == ST_HIGH) begin
                rdata_d[31:16] = sram_dq_in;
            end else begin
                rdata_d[15:0] = sram_dq_in;
            end
        end
    end

    // WE rises on the last count of each write phase so data is still held at the edge.
    always_comb begin
        ready       = 1'b1;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_ce_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        case (state_q)
            ST_IDLE: ready = ~(rd_en | wr_en);
            ST_LOW, ST_HIGH: begin
                ready     = 1'b0;
                sram_addr = {word_q, state_q == ST_HIGH};
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (op_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = w_last;
                    sram_dq_out = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign read_data = rdata_q;

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (!ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// tb_sram_controller: self-checking bench with an SRAM model and a word-level reference memory.
// Rev 1.0
`default_nettype none

module tb_sram_controller;

    localparam int          W    = 5;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic          sram_ce_n;
    logic          sram_ub_n;
    logic          sram_lb_n;
`ifdef SRAM_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram_mem  [int unsigned];
    logic [31:0] ref_words [int unsigned];
    logic [31:0] last_rd;

    sram_controller #(
        .WAIT_CYCLES(W),
        .ADDR_BASE  (BASE),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
`ifdef SRAM_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] sram_default(input logic [31:0] hw);
        return hw[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] sram_read(input logic [31:0] hw);
        if (sram_mem.exists(hw)) return sram_mem[hw];
        return sram_default(hw);
    endfunction

    // Board SRAM: acts mid-cycle, when the controller outputs are stable.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[32'(sram_addr)] = sram_dq_out;
        sram_dq_in = !sram_oe_n ? sram_read(32'(sram_addr)) : 16'h0000;
    end

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return (d >> 2) & ((32'd1 << (AW - 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_word(input int unsigned w);
        if (ref_words.exists(w)) return ref_words[w];
        return {sram_default(2 * w + 1), sram_default(2 * w)};
    endfunction

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit hold, input int drop_at,
                           input string name);
        int          k;
        int          frozen;
        int          j;
        bit          hi;
        bit          is_wr;
        bit          strobe_ok;
        int          bad_k;
        int unsigned w;
        logic [AW-1:0] exp_addr;
        logic [31:0] exp_rd;
        is_wr     = wr;
        w         = word_of(addr);
        exp_rd    = is_wr ? last_rd : exp_word(w);
        rd_en     = rd;
        wr_en     = wr;
        address   = addr;
        write_data = data;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_cycle0 got=%b exp=0", name, ready);
        end
        frozen    = 1;
        k         = 0;
        strobe_ok = 1'b1;
        bad_k     = -1;
        while (1) begin
            @(posedge clk);
            #1;
            k++;
            if (k == drop_at) begin
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            #1;
            if (ready === 1'b1 || k > 4 * W + 4) break;
            frozen++;
            if (k <= 2 * W) begin
                j        = (k - 1) % W;
                hi       = (k > W);
                exp_addr = AW'(2 * w + (hi ? 1 : 0));
                if (sram_ce_n !== 1'b0 || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0 ||
                    sram_addr !== exp_addr ||
                    sram_oe_n !== is_wr || sram_dq_oe !== is_wr ||
                    sram_we_n !== (is_wr ? (j == W - 1) : 1'b1) ||
                    (is_wr && sram_dq_out !== (hi ? data[31:16] : data[15:0]))) begin
                    if (strobe_ok) bad_k = k;
                    strobe_ok = 1'b0;
                end
            end
        end
        checks++;
        if (frozen != 2 * W + 1) begin
            failures++;
            $display("FAIL %s frozen_cycles got=%0d exp=%0d", name, frozen, 2 * W + 1);
        end
        checks++;
        if (!strobe_ok) begin
            failures++;
            $display("FAIL %s strobes bad at cycle %0d addr=%h we_n=%b oe_n=%b dq_oe=%b dq=%h exp_word=%0d",
                     name, bad_k, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out, w);
        end
        checks++;
        if (read_data !== exp_rd ||
            {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            failures++;
            $display("FAIL %s done read_data got=%h exp=%h strobes=%b", name, read_data, exp_rd,
                     {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n});
        end
        if (is_wr) ref_words[w] = data;
        else last_rd = exp_rd;
        if (!hold) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
        @(posedge clk);
        #2;
        if (!hold) begin
            checks++;
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL %s idle_ready got=%b exp=1", name, ready);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = '0;
        write_data = '0;
        last_rd = '0;
        #12;
        checks++;
        if (ready !== 1'b1 || read_data !== 32'h0 || sram_addr !== '0 || sram_dq_out !== 16'h0 ||
            sram_dq_oe !== 1'b0 ||
            {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_values ready=%b rd=%h addr=%h dq=%h oe=%b strobes=%b exp idle/zero/all-high",
                     ready, read_data, sram_addr, sram_dq_out, sram_dq_oe,
                     {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n});
        end
        rd_en = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_follows_req got=%b exp=0", ready);
        end
        rd_en = 1'b0;
`ifdef SRAM_STALL_CNT_EN
        checks++;
        if (stall_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_store;
        run_txn(1'b0, 1'b1, BASE, 32'hDEADBEEF, 1'b0, -1, "store");
        checks++;
        if (sram_read(0) !== 16'hBEEF || sram_read(1) !== 16'hDEAD) begin
            failures++;
            $display("FAIL store_memory got=%h_%h exp=DEAD_BEEF", sram_read(1), sram_read(0));
        end
    endtask

    task automatic test_load;
        sram_mem[2]  = 16'h1234;
        sram_mem[3]  = 16'hABCD;
        ref_words[1] = 32'hABCD1234;
        run_txn(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0, -1, "load");
    endtask

    task automatic test_simultaneous;
        run_txn(1'b1, 1'b1, BASE + 32'd40, 32'h55AA_1357, 1'b0, -1, "simultaneous");
        run_txn(1'b1, 1'b0, BASE + 32'd40, 32'h0, 1'b0, -1, "simultaneous_readback");
    endtask

    task automatic test_deassert;
        run_txn(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0, 3, "deassert_mid");
    endtask

    task automatic test_reset_mid;
        int k;
        rd_en = 1'b0;
        wr_en = 1'b1;
        address = BASE + 32'd400;
        write_data = 32'hCAFE_F00D;
        k = 0;
        while (k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111 ||
            sram_dq_oe !== 1'b0 || sram_addr !== '0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid strobes=%b dq_oe=%b addr=%h rd=%h exp 11111/0/0/0",
                     {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, sram_dq_oe,
                     sram_addr, read_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready got=%b exp=1", ready);
        end
        last_rd = 32'h0;
        sram_mem.delete(200);
        sram_mem.delete(201);
        ref_words.delete(100);
    endtask

    task automatic test_random;
        logic [31:0] a;
        bit          wr;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            run_txn(~wr | 1'($urandom_range(0, 1)), wr, a, $urandom,
                    (i != 23) && ($urandom_range(0, 2) == 0), -1, "random");
        end
    endtask

    task automatic test_back_to_back;
`ifdef SRAM_STALL_CNT_EN
        logic [31:0] before;
        before = stall_count;
`endif
        run_txn(1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b1, -1, "b2b_first");
        run_txn(1'b1, 1'b0, BASE + 32'd12, 32'h0, 1'b0, -1, "b2b_second");
`ifdef SRAM_STALL_CNT_EN
        checks++;
        if (stall_count - before !== 32'd22) begin
            failures++;
            $display("FAIL stall_count delta got=%0d exp=22", stall_count - before);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_simultaneous();
        test_deassert();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Sequences the single-port 16-bit external SRAM on behalf of the MEM stage. It splits each 32-bit load or store into two half-word accesses, each lasting a fixed number of wait cycles. It drives `ready` low for the whole transaction, and the datapath uses `~ready` as a pipeline freeze. It sits between MemStage and the board SRAM pins and replaces the on-chip data memory.

## Interface
- `WAIT_CYCLES`, default 5: cycles per half-word access, legal range 2..15.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM half-word 0.
- `SRAM_AW`, default 18: SRAM half-word address width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `rd_en  in  1`: load request from the MEM stage.
- `wr_en  in  1`: store request from the MEM stage.
- `address  in  32`: byte address; bits [1:0] are ignored.
- `write_data  in  32`: store data.
- `read_data  out  32`: load data, registered.
- `ready  out  1`: transaction complete, or no request pending.
- `sram_addr  out  SRAM_AW`: SRAM half-word address.
- `sram_dq_out  out  16`: data driven to the SRAM.
- `sram_dq_in  in  16`: data returned from the SRAM.
- `sram_dq_oe  out  1`: pad output enable.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each: SRAM strobes, active-low.

## Operation
- States are IDLE, LOW, HIGH and DONE.
- **IDLE**
  - `ready = ~(rd_en | wr_en)`, combinational.
  - On a request: latch `op` (write if `wr_en`, else read), latch `write_data`, and compute `word = (address - ADDR_BASE) >> 2` truncated to SRAM_AW-1 bits (wraps, no range check).
  - Transition to LOW with `cnt = 0`.
- **Simultaneous requests:** if `rd_en` and `wr_en` are both high, the write wins and `read_data` is left unchanged.
- **LOW and HIGH phases**
  - Half-word address is `{word, 0}` in LOW and `{word, 1}` in HIGH.
  - Write phase: `sram_dq_out` carries `write_data[15:0]` in LOW and `[31:16]` in HIGH.
  - `cnt` runs 0..WAIT_CYCLES-1. On the last count the state advances LOW→HIGH→DONE and `cnt` clears.
- **Strobes while in LOW or HIGH**
  - `sram_ce_n`, `sram_ub_n` and `sram_lb_n` are 0.
  - Read: `sram_oe_n = 0`, `sram_we_n = 1`, `sram_dq_oe = 0`.
  - Write: `sram_oe_n = 1` and `sram_dq_oe = 1`. `sram_we_n = 0` for `cnt < WAIT_CYCLES-1` and 1 on the last count, giving data hold at the WE rising edge.
- **Read capture:** on the last count, the rising edge latches `sram_dq_in` into `read_data[15:0]` (LOW) or `read_data[31:16]` (HIGH).
- **DONE:** `ready = 1` and all strobes are high. Transition to IDLE unconditionally.
- **Requests after start:** deassertion is ignored and the transaction always completes. Request changes while not in IDLE are ignored.
- **Back-to-back:** a request still high in IDLE (the next frozen instruction) starts a new transaction; there is no combining.

## Timing
- A request first seen at cycle 0 produces `ready = 0` for cycles 0..2·WAIT_CYCLES and `ready = 1` at cycle 2·WAIT_CYCLES+1.
  - With the default, that is 11 frozen cycles and ready at cycle 11.
- `read_data` is valid from DONE onward and holds until the next read capture.
- Non-memory instructions see `ready = 1` with zero latency.
- **Reset values:**
  - State IDLE, `cnt = 0`, `read_data = 0`, `sram_addr = 0`.
  - `sram_dq_out = 0`, `sram_dq_oe = 0`.
  - All `*_n` strobes = 1.
  - `ready = ~(rd_en | wr_en)`.
- **Reset mid-transaction:** immediate return to the reset values; a partial write leaves the SRAM contents undefined.

## Configuration
- Macro: `SRAM_STALL_CNT_EN`.
- **Defined:** adds output `stall_count  out  32`.
  - Reset value 0.
  - Increments on every cycle with `ready = 0`; saturates at 32'hFFFFFFFF.
- **Undefined:** the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state encodings (IDLE = 0, LOW = 1, HIGH = 2, DONE = 3);
  - the defaults for `ADDR_BASE` and `WAIT_CYCLES`;
  - the 16-bit SRAM data width constant.
- One sub-module, `sram_wait_counter`: a clearable counter that asserts `last` at WAIT_CYCLES-1.

## Test plan
- **Store:** write 32'hDEADBEEF at 1024 → `sram_addr` 0 then 1 carry BEEF then DEAD; `we_n` low 4 cycles per phase, high on cycle 5; `ready` rises at cycle 11.
- **Load:** read 1028 with the model returning 1234 at half-word 2 and ABCD at half-word 3 → `read_data` 32'hABCD1234 in DONE; `ready` low for exactly 11 cycles.
- **Simultaneous requests:** `rd_en` = `wr_en` = 1 → write transaction, `read_data` unchanged, `dq_oe` high in both phases.
- **Deassert mid-op:** drop `rd_en` at cycle 3 → transaction still completes, `ready` high at cycle 11, then IDLE.
- **Reset mid-op:** assert `rst` low at cycle 6 of a write → all strobes 1 and `dq_oe` 0 immediately; after release, `ready = 1` with no request.
- **Stall counter (`SRAM_STALL_CNT_EN`):** two back-to-back loads → `stall_count` = 22.
